// File: rtl/layer0_pkg.sv
// Shared constants, kernel table and pixel/tap helpers for the layer-0 convolution engine.
package layer0_pkg;

  localparam int unsigned IMG_W    = 64;
  localparam int unsigned DATA_W   = 20;
  localparam int unsigned OUT_W    = 19;
  localparam int unsigned COORD_W  = $clog2(IMG_W);
  localparam int unsigned ADDR_W   = 2 * COORD_W;
  localparam int unsigned CRD_X_W  = COORD_W + 1;
  localparam int unsigned PROD_W   = 2 * DATA_W;
  localparam int unsigned ACC_W    = 44;
  localparam int unsigned FRAC_W   = 16;
  localparam int unsigned NUM_TAPS = 9;
  localparam int unsigned NUM_STEPS = 12;
  localparam int unsigned STEP_W   = 4;

  localparam logic [DATA_W-1:0] BIAS = 20'h01310;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } pix_pos_t;

  typedef struct packed {
    logic [1:0] i;
    logic [1:0] j;
  } tap_t;

  // 3x3 kernel in signed 4.16, row-major.
  function automatic logic [DATA_W-1:0] kernel_coef(input logic [STEP_W-1:0] k);
    case (k)
      4'd0:    return 20'h0A89E;
      4'd1:    return 20'h092D5;
      4'd2:    return 20'h06D43;
      4'd3:    return 20'h01004;
      4'd4:    return 20'hF8F71;
      4'd5:    return 20'hF6E54;
      4'd6:    return 20'hFA6D7;
      4'd7:    return 20'hFC834;
      4'd8:    return 20'hFAC19;
      default: return '0;
    endcase
  endfunction

  // Pixel counter to (row, col) in 2x2-block order: TL, TR, BL, BR, blocks raster-scanned.
  function automatic pix_pos_t pix_pos(input logic [ADDR_W-1:0] p);
    pix_pos_t pos;
    pos.row = {p[ADDR_W-1:COORD_W+1], p[1]};
    pos.col = {p[COORD_W:2], p[0]};
    return pos;
  endfunction

  function automatic tap_t tap_of(input logic [STEP_W-1:0] k);
    tap_t t;
    case (k)
      4'd0, 4'd1, 4'd2: t.i = 2'd0;
      4'd3, 4'd4, 4'd5: t.i = 2'd1;
      default:          t.i = 2'd2;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: t.j = 2'd0;
      4'd1, 4'd4, 4'd7: t.j = 2'd1;
      default:          t.j = 2'd2;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/layer0_conv_mac.sv
// Multiply-accumulate datapath: masked tap products, bias, round-half-up and ReLU result register.
module conv_mac
  import layer0_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_acc_en,
  input  logic              i_tap_ok,
  input  logic [DATA_W-1:0] i_pix,
  input  logic [DATA_W-1:0] i_coef,
  input  logic              i_res_en,
  output logic [OUT_W-1:0]  o_res
);

  localparam logic [ACC_W-1:0] BIAS_ACC =
    {{(ACC_W-DATA_W-FRAC_W){BIAS[DATA_W-1]}}, BIAS, {FRAC_W{1'b0}}};
  localparam logic [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_W - 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  res_q, res_d;
  logic [PROD_W-1:0] pix_x_c, coef_x_c, prod_c;
  logic [ACC_W-1:0]  prod_acc_c, sum_c;
  logic [DATA_W-1:0] val_c;
  logic              unused_sum_c;

  always_comb begin
    acc_d      = acc_q;
    res_d      = res_q;
    pix_x_c    = {{(PROD_W-DATA_W){i_pix[DATA_W-1]}}, i_pix};
    coef_x_c   = {{(PROD_W-DATA_W){i_coef[DATA_W-1]}}, i_coef};
    // Low PROD_W bits of the extended product equal the signed 8.32 product.
    prod_c     = i_tap_ok ? (pix_x_c * coef_x_c) : '0;
    prod_acc_c = {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
    sum_c      = acc_q + BIAS_ACC + RND_HALF;
    val_c      = sum_c[FRAC_W+DATA_W-1:FRAC_W];

    if (i_clr) begin
      acc_d = '0;
    end else if (i_acc_en) begin
      acc_d = acc_q + prod_acc_c;
    end

    if (i_res_en) begin
      res_d = val_c[DATA_W-1] ? '0 : val_c[OUT_W-1:0];
    end
  end

  assign unused_sum_c = ^{sum_c[ACC_W-1:FRAC_W+DATA_W], sum_c[FRAC_W-1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign o_res = res_q;

endmodule

// File: rtl/layer0_conv.sv
// Layer-0 engine: sequences 12-step pixel passes over the image, addresses padded 3x3 taps, emits results.
module layer0_conv
  import layer0_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_iaddr,
  input  logic [DATA_W-1:0] i_idata,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_data
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
  logic                tap_ok_q, tap_ok_d;
  logic                tap_ok_dly_q, tap_ok_dly_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;

  pix_pos_t            pos_c;
  tap_t                tap_c;
  logic [CRD_X_W-1:0]  tap_r_c, tap_c_c;
  logic                mac_clr_c, mac_acc_en_c, mac_res_en_c;
  logic [DATA_W-1:0]   mac_coef_c;

  // Sequencer: step/pixel counters and the IDLE/RUN state.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pix_d   = pix_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start && !busy_q) begin
          state_d = RUN;
          step_d  = '0;
          pix_d   = '0;
        end
      end
      RUN: begin
        if (step_q == STEP_W'(NUM_STEPS - 1)) begin
          valid_d = 1'b1;
          step_d  = '0;
          pix_d   = pix_q + ADDR_W'(1);
          if (&pix_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy spans the cycle carrying o_done so a back-to-back start cannot slip in.
    busy_d = (state_d == RUN) || done_d;
  end

  // Tap address for the step about to begin; out-of-image taps read address 0 and are masked.
  always_comb begin
    pos_c   = pix_pos(pix_d);
    tap_c   = tap_of(step_d);
    tap_r_c = CRD_X_W'(pos_c.row) + CRD_X_W'(tap_c.i) - CRD_X_W'(1);
    tap_c_c = CRD_X_W'(pos_c.col) + CRD_X_W'(tap_c.j) - CRD_X_W'(1);

    tap_ok_d = (state_d == RUN) && (step_d < STEP_W'(NUM_TAPS)) &&
               !tap_r_c[COORD_W] && !tap_c_c[COORD_W];
    iaddr_d  = tap_ok_d ? {tap_r_c[COORD_W-1:0], tap_c_c[COORD_W-1:0]} : '0;
    tap_ok_dly_d = tap_ok_q;
  end

  // Data for the tap issued in step s arrives in step s+1.
  always_comb begin
    mac_clr_c    = (step_q == '0);
    mac_acc_en_c = (state_q == RUN) && (step_q >= STEP_W'(1)) &&
                   (step_q <= STEP_W'(NUM_TAPS));
    mac_res_en_c = (state_q == RUN) && (step_q == STEP_W'(NUM_TAPS + 1));
    mac_coef_c   = kernel_coef(step_q - STEP_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      pix_q        <= '0;
      iaddr_q      <= '0;
      tap_ok_q     <= 1'b0;
      tap_ok_dly_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      pix_q        <= pix_d;
      iaddr_q      <= iaddr_d;
      tap_ok_q     <= tap_ok_d;
      tap_ok_dly_q <= tap_ok_dly_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
    end
  end

  conv_mac u_mac (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (mac_clr_c),
    .i_acc_en (mac_acc_en_c),
    .i_tap_ok (tap_ok_dly_q),
    .i_pix    (i_idata),
    .i_coef   (mac_coef_c),
    .i_res_en (mac_res_en_c),
    .o_res    (o_data)
  );

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_iaddr = iaddr_q;
  assign o_valid = valid_q;

endmodule
